// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types, constants and round-robin helper for the UART tx arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // First set bit of req at or after ptr, wrapping modulo n; returns ptr when req is empty.
  function automatic int rr_pick(input logic [15:0] req, input int ptr, input int n);
    int k;
    rr_pick = ptr;
    for (int i = 15; i >= 0; i--) begin
      if (i < n) begin
        k = (ptr + i) % n;
        if (req[k[3:0]]) rr_pick = k;
      end
    end
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// rtl/uart_rr_picker.sv - combinational round-robin selector (request vector + pointer -> index, any)
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  always_comb begin
    any = |req;
    idx = ID_W'(rr_pick(16'(req), int'(ptr), NUM_REQ));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter onto one UART tx byte port
// Optional header byte {TAG_NIBBLE, grant_id} before each packet when UART_ARB_TAG_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_in,
  output logic                   uart_in_valid,
  input  logic                   tx_ready,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy
);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  logic            free;
  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic [7:0]      g_data;
  logic            g_valid;
  logic            g_last;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req (req_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // The output slot can take a new byte if empty or being drained this cycle.
  assign free    = ~valid_q | tx_ready;
  assign g_data  = req_data[8*int'(grant_q) +: 8];
  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = valid_q & ~tx_ready;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
`ifdef UART_ARB_TAG_EN
          state_d = ST_HDR;
`else
          state_d = ST_SEND;
`endif
        end
      end
      ST_HDR: begin
`ifdef UART_ARB_TAG_EN
        if (free) begin
          data_d  = {TAG_NIBBLE, 4'(grant_q)};
          valid_d = 1'b1;
          state_d = ST_SEND;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_SEND: begin
        req_ready[grant_q] = free;
        if (g_valid && free) begin
          data_d  = g_data;
          valid_d = 1'b1;
          if (g_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Release only once the last byte has left, so packets never interleave.
        if (free) begin
          ptr_d   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign uart_in       = data_q;
  assign uart_in_valid = valid_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE) | valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef UART_ARB_TAG_EN
  localparam int TAGGED = 1;
`else
  localparam int TAGGED = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*8-1:0] req_data  = '0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_in;
  logic           uart_in_valid;
  logic           tx_ready = 1'b1;
  logic [IDW-1:0] grant_id;
  logic           busy;

  logic [8:0]     txq [N][$];
  logic [7:0]     outq[$];
  logic [7:0]     exp_q[$];
  logic [N-1:0]   acc;
  int             checks   = 0;
  int             failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_in       (uart_in),
    .uart_in_valid (uart_in_valid),
    .tx_ready      (tx_ready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  // Requester models and output monitor: one process owns all req_* signals.
  always @(posedge clk) begin
    logic [8:0] e;
    if (uart_in_valid === 1'b1 && tx_ready === 1'b1 && rst !== 1'b1) outq.push_back(uart_in);
    acc = req_valid & req_ready & {N{~rst}};
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc[r] && txq[r].size() > 0) void'(txq[r].pop_front());
      if (txq[r].size() > 0) begin
        e = txq[r][0];
        req_valid[r]       = 1'b1;
        req_last[r]        = e[8];
        req_data[8*r +: 8] = e[7:0];
      end else begin
        req_valid[r]       = 1'b0;
        req_last[r]        = 1'b0;
        req_data[8*r +: 8] = 8'h00;
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input bit last);
    txq[r].push_back({last, d});
  endtask

  task automatic ex_hdr(input int r);
    if (TAGGED != 0) exp_q.push_back(8'hA0 | 8'(r));
  endtask

  task automatic ex(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (outq.size() >= exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < N; r++) txq[r].delete();
    @(negedge clk);
    rst = 1'b0;
    outq.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (uart_in_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", uart_in_valid); end
    checks++; if (uart_in !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", uart_in); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    int  t_pen, t_last, gid_bad;
    logic busy_pen;
    logic [7:0] got;
    t_pen = -1; t_last = -1; gid_bad = 0; busy_pen = 1'b0;
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b1);
    ex_hdr(0); ex(8'h11); ex(8'h22);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && grant_id !== 2'd0) gid_bad++;
      if (outq.size() == exp_q.size() - 1 && t_pen < 0) begin t_pen = c; busy_pen = busy; end
      if (outq.size() == exp_q.size()) begin t_last = c; break; end
    end
    checks++; if (t_last < 0) begin failures++; $display("FAIL pkt0_timeout got=%0d bytes exp=%0d", outq.size(), exp_q.size()); end
    checks++; if (t_last - t_pen != 1) begin failures++; $display("FAIL pkt0_throughput got=%0d cycles exp=1", t_last - t_pen); end
    checks++; if (busy_pen !== 1'b1) begin failures++; $display("FAIL pkt0_busy_mid got=%b exp=1", busy_pen); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pkt0_busy_end got=%b exp=0", busy); end
    checks++; if (uart_in_valid !== 1'b0) begin failures++; $display("FAIL pkt0_valid_end got=%b exp=0", uart_in_valid); end
    checks++; if (gid_bad != 0) begin failures++; $display("FAIL pkt0_grant got=%0d bad cycles exp=0", gid_bad); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL pkt0_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    repeat (2) @(negedge clk);
    outq.delete(); exp_q.delete();
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] got;
    do_reset();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b1); push(1, 8'hC1, 1'b0); push(1, 8'hC2, 1'b1);
    push(3, 8'hB1, 1'b0); push(3, 8'hB2, 1'b1);
    ex_hdr(1); ex(8'hA1); ex(8'hA2);
    ex_hdr(3); ex(8'hB1); ex(8'hB2);
    ex_hdr(1); ex(8'hC1); ex(8'hC2);
    wait_out(ok);
    checks++; if (!ok || outq.size() != exp_q.size()) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    outq.delete(); exp_q.delete();
  endtask

  task automatic test_single_byte();
    bit ok;
    int gid_bad;
    logic [7:0] got;
    gid_bad = 0;
    push(2, 8'h5A, 1'b1);
    ex_hdr(2); ex(8'h5A);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (busy === 1'b1 && grant_id !== 2'd2) gid_bad++;
    end
    checks++; if (outq.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    checks++; if (outq.size() > 0 && outq[outq.size()-1] !== 8'h5A) begin failures++; $display("FAIL single_byte got=%h exp=5a", outq[outq.size()-1]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
    checks++; if (gid_bad != 0) begin failures++; $display("FAIL single_grant got=%0d bad cycles exp=0", gid_bad); end
    outq.delete(); exp_q.delete();
    // Pointer should now sit at 3, so requester 3 beats requester 0.
    push(0, 8'hD0, 1'b1); push(3, 8'hD3, 1'b1);
    ex_hdr(3); ex(8'hD3); ex_hdr(0); ex(8'hD0);
    wait_out(ok);
    checks++; if (!ok || outq.size() != exp_q.size()) begin failures++; $display("FAIL ptr3_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL ptr3_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    outq.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] got;
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
    ex_hdr(0); ex(8'h71); ex(8'h72); ex(8'h73);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (outq.size() >= 1 + TAGGED) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL bp_start got=%0d bytes exp=%0d", outq.size(), 1 + TAGGED); end
    tx_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (uart_in_valid !== 1'b1) begin failures++; $display("FAIL bp_valid%0d got=%b exp=1", c, uart_in_valid); end
      checks++; if (uart_in !== 8'h72) begin failures++; $display("FAIL bp_data%0d got=%h exp=72", c, uart_in); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", c, req_ready); end
    end
    tx_ready = 1'b1;
    wait_out(ok);
    checks++; if (!ok || outq.size() != exp_q.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    outq.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    logic [7:0] got;
    tx_ready = 1'b0;
    push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b0); push(1, 8'h83, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (uart_in_valid === 1'b1 && busy === 1'b1) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_fill got=%b exp=1", uart_in_valid); end
    rst = 1'b1;
    for (int r = 0; r < N; r++) txq[r].delete();
    @(negedge clk);
    checks++; if (uart_in_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", uart_in_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rstmid_ready got=%b exp=0000", req_ready); end
    checks++; if (outq.size() != 0) begin failures++; $display("FAIL rstmid_leak got=%0d exp=0", outq.size()); end
    rst = 1'b0;
    tx_ready = 1'b1;
    outq.delete(); exp_q.delete();
    // Pointer back at 0: requester 0 wins over requester 3.
    push(0, 8'hE0, 1'b1); push(3, 8'hE3, 1'b1);
    ex_hdr(0); ex(8'hE0); ex_hdr(3); ex(8'hE3);
    wait_out(ok);
    checks++; if (!ok || outq.size() != exp_q.size()) begin failures++; $display("FAIL rstmid_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    outq.delete(); exp_q.delete();
  endtask

  task automatic test_tag();
    bit ok;
    logic [7:0] got;
    push(2, 8'h33, 1'b1);
    ex_hdr(2); ex(8'h33);
    wait_out(ok);
    checks++; if (!ok || outq.size() != exp_q.size()) begin failures++; $display("FAIL tag_count got=%0d exp=%0d", outq.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      got = (i < outq.size()) ? outq[i] : 8'hxx;
      checks++; if (got !== exp_q[i]) begin failures++; $display("FAIL tag_byte%0d got=%h exp=%h", i, got, exp_q[i]); end
    end
    outq.delete(); exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_single_byte();
    test_backpressure();
    test_reset_mid_packet();
    test_tag();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter byte port (uart_in / uart_in_valid / tx_ready) between NUM_REQ independent byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant is held from the first byte to the byte flagged last, so packets never interleave on TxD.
- Sits between on-chip masters (debug console, status reporter, bus bridge) and the uart top-level tx input.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- ID_W, $clog2(NUM_REQ), width of grant_id; derived, not overridden.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- req_data  input  NUM_REQ*8  byte from requester i on bits [8i+7:8i]
- req_valid  input  NUM_REQ  requester i has a byte
- req_last  input  NUM_REQ  byte from requester i ends its packet
- req_ready  output  NUM_REQ  requester i byte accepted this cycle when valid&ready
- uart_in  output  8  byte to UART transmitter
- uart_in_valid  output  1  uart_in holds a byte not yet taken
- tx_ready  input  1  transmitter accepts uart_in this cycle when uart_in_valid
- grant_id  output  ID_W  index of current owner; valid while busy
- busy  output  1  a packet is in progress or the output byte is not yet taken

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, rr pointer=0, uart_in=8'h00, uart_in_valid=0, req_ready=0, grant_id=0, busy=0.
- Reset mid-packet discards the held byte. Requesters must restart their packet.
- Output register: uart_in/uart_in_valid are registered. A byte is consumed on a cycle with uart_in_valid&tx_ready. uart_in_valid stays high and uart_in stays stable until consumed.
- Slot free: free = ~uart_in_valid | tx_ready.
- FSM states: IDLE, SEND, DRAIN.
- IDLE:
  - If any req_valid, select the first asserted index at or after rr pointer, wrapping modulo NUM_REQ.
  - Latch it into grant_id, go to SEND, busy=1.
  - The arbitration cycle accepts no data.
- SEND:
  - req_ready[grant_id] = free. All other req_ready bits are 0.
  - On req_valid[g]&req_ready[g], load uart_in <= byte and set uart_in_valid=1 on the next cycle. Latency is 1 cycle from accept to uart_in_valid.
  - If req_last[g] is set on that byte, go to DRAIN.
  - Requester deasserting valid mid-packet keeps the grant. There is no timeout.
- DRAIN:
  - req_ready=0.
  - When the final byte is consumed (or uart_in_valid already 0), set rr pointer=(grant_id+1) mod NUM_REQ, go to IDLE, busy=0 next cycle.
- Throughput: with tx_ready held high, one byte per cycle is sustained in SEND.
- Simultaneous consume and load in the same cycle: new byte replaces old, uart_in_valid stays 1.
- Single-byte packet (valid&last on the first accepted byte) behaves normally: SEND then DRAIN.
- Non-granted requesters are never starved: worst-case wait is NUM_REQ-1 packets.

Optional Feature:
- Macro UART_ARB_TAG_EN.
- Defined:
  - Adds state HDR between IDLE and SEND.
  - HDR loads uart_in = {4'hA, grant_id zero-extended to 4 bits} as the first byte of every packet, with req_ready=0 until that byte is loaded.
  - Adds one cycle to arbitration-to-first-payload latency.
- Undefined: no HDR state; payload bytes only. Behaviour is otherwise identical.

Decomposition:
- Shared package uart_arb_pkg:
  - FSM state enum (IDLE, HDR, SEND, DRAIN)
  - TAG_NIBBLE=4'hA
  - function rr_pick(req, ptr) returning the next index
- One sub-module: uart_rr_picker, a combinational round-robin priority selector (req vector + pointer -> index + any).
- The top holds the FSM and output register.

Test Plan:
- tx_ready=1; req0 sends packet 8'h11,8'h22(last) -> uart_in sequence 11,22. busy falls 1 cycle after 22 is consumed. grant_id=0 throughout.
- req1 and req3 both valid from reset, 2-byte packets 8'hA1,A2 and 8'hB1,B2 -> order A1,A2,B1,B2. Then req1 re-requesting loses to pending req3 packet order (pointer=2 after req1).
- Backpressure: tx_ready low for 5 cycles mid-packet -> uart_in holds value stable, req_ready low, no byte lost or duplicated.
- Single-byte packet 8'h5A from req2 with last on the first byte -> exactly one output byte, FSM returns to IDLE, rr pointer=3.
- Assert rst during SEND with uart_in_valid=1 -> next cycle uart_in_valid=0, busy=0, req_ready=0. A new packet then arbitrates from pointer 0.
- With UART_ARB_TAG_EN, req2 sends 8'h33(last) -> output 8'hA2 then 8'h33. Without the macro -> 8'h33 only.
